// File: rtl/barrel_unrotator.sv
// barrel_unrotator: multi-cycle inverse of a single-cycle right-rotate barrel shifter.
// Accepts a rotated word plus the rotate amount that produced it, then rotates the
// word back one bit per clock. Valid/ready handshakes on both sides.
// Optional feature macro: UNROT_BIDIR_EN adds a 'dir' input (0: rotate left, 1: right).
module barrel_unrotator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift,
`ifdef UNROT_BIDIR_EN
    input  logic             dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRot, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rot_q, rot_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rot_step;
    logic             rot_right;
    logic             accept;

`ifdef UNROT_BIDIR_EN
    logic dir_q, dir_d;

    // Direction is captured with the word so later changes on 'dir' are ignored.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end

    // Load direction only on the accept edge.
    always_comb begin
        dir_d = dir_q;
        if (accept) begin
            dir_d = dir;
        end
    end

    assign rot_right = dir_q;
`else
    assign rot_right = 1'b0;
`endif

    assign in_ready  = (state_q == StIdle) && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign data_out  = dout_q;

    // One-bit rotation of the working register; left undoes the upstream right rotate.
    always_comb begin
        rot_step = rot_right ? {rot_q[0], rot_q[WIDTH-1:1]} : {rot_q[WIDTH-2:0], rot_q[WIDTH-1]};
    end

    // State, working register, remaining-step count and output register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            rot_q   <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic; data_out is loaded only on entry to DONE so it stays put afterwards.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        count_d = count_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rot_d   = data_in;
                    count_d = shift;
                    if (shift == '0) begin
                        state_d = StDone;
                        dout_d  = data_in;
                    end else begin
                        state_d = StRot;
                    end
                end
            end
            StRot: begin
                rot_d   = rot_step;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = StDone;
                    dout_d  = rot_step;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_barrel_unrotator.sv
// Self-checking bench for barrel_unrotator (WIDTH=8). Expected values come from
// arithmetic rotate functions; latency is expected as shift+1 edges.
module tb_barrel_unrotator;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [2:0] shift;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       busy;
`ifdef UNROT_BIDIR_EN
    logic       dir;
`endif

    int total = 0;
    int bad   = 0;

    barrel_unrotator #(.WIDTH(W)) dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift     (shift),
`ifdef UNROT_BIDIR_EN
        .dir       (dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
        int v;
        int r;
        v = int'(x);
        r = ((v << s) | (v >> (W - s))) & 255;
        return r[7:0];
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] x, input int s);
        int v;
        int r;
        v = int'(x);
        r = ((v >> s) | (v << (W - s))) & 255;
        return r[7:0];
    endfunction

    // Called one time unit after a clock edge with the block idle.
    task automatic run_word(input string tag, input logic [7:0] d, input int sh, input int hold,
                            input logic [7:0] exp);
        int edges;
        logic [7:0] held;
        check({tag, " in_ready idle"}, in_ready, 1);
        data_in   = d;
        shift     = sh[2:0];
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        shift    = 3'($urandom);
        edges    = 1;
        while (!out_valid && edges < W + 4) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, " latency"}, edges, sh + 1);
        check({tag, " data_out"}, data_out, exp);
        check({tag, " busy done"}, busy, 1);
        check({tag, " in_ready done"}, in_ready, 0);
        held = data_out;
        for (int k = 0; k < hold; k++) begin
            // Source offers a junk word that must not be taken while in DONE.
            in_valid = 1'b1;
            data_in  = 8'($urandom);
            shift    = 3'($urandom);
            @(posedge clk);
            #1;
            check({tag, " held data"}, data_out, held);
            check({tag, " held valid"}, out_valid, 1);
            check({tag, " held in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " valid drop"}, out_valid, 0);
        check({tag, " busy idle"}, busy, 0);
        check({tag, " data kept"}, data_out, held);
    endtask

    initial begin
        clear     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 8'h00;
        shift     = 3'd0;
`ifdef UNROT_BIDIR_EN
        dir       = 1'b0;
`endif
        #2;
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 0);
        check("reset data_out", data_out, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        check("post reset in_ready", in_ready, 1);

        // T1..T3 directed
        run_word("t1", 8'hA5, 5, 0, 8'hB4);
        run_word("t2", 8'h3C, 0, 0, 8'h3C);
        run_word("t3", 8'h1E, 3, 10, 8'hF0);

        // T4: clear in the middle of a rotation
        data_in  = 8'h80;
        shift    = 3'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t4 busy before clear", busy, 1);
        clear = 1'b1;
        #1;
        check("t4 clear out_valid", out_valid, 0);
        check("t4 clear busy", busy, 0);
        check("t4 clear in_ready", in_ready, 0);
        check("t4 clear data_out", data_out, 0);
        #1;
        clear = 1'b0;
        @(posedge clk);
        #1;
        check("t4 no partial valid", out_valid, 0);
        run_word("t4 next", 8'h01, 1, 0, 8'h02);

        // Randomized words with random back-pressure
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            int sh;
            d  = 8'($urandom);
            sh = int'($urandom_range(0, W - 1));
            run_word("rand", d, sh, int'($urandom_range(0, 3)), rotl(d, sh));
        end

        // T5: every value at every shift, pre-rotated right
        for (int v = 0; v < 256; v++) begin
            for (int s = 0; s < W; s++) begin
                run_word("t5", rotr(8'(v), s), s, 0, 8'(v));
            end
        end

`ifdef UNROT_BIDIR_EN
        dir = 1'b1;
        run_word("t6", 8'h81, 1, 0, 8'hC0);
        dir = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
